// File: rtl/sram_mem_controller.sv
// Sequences 32-bit MEM-stage loads/stores onto a 16-bit async SRAM as two half-word phases.
// Optional address range check with err output: define SRAM_RANGE_CHECK_EN.
module sram_mem_controller #(
    parameter int          ADDR_W      = 18,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              freeze,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_we_n,
    output logic              sram_oe_n
`ifdef SRAM_RANGE_CHECK_EN
    ,
    output logic              err
`endif
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              rd_p0;
    logic [ADDR_W-2:0] widx_p0;
    logic [31:0]       wdata_p0;

    logic req;
    logic start;
    logic phase_end;
    logic in_phase;
    logic wr_phase;
    logic rd_phase;
    logic range_bad;

    assign req       = mem_read | mem_write;
    assign start     = (state == IDLE) && req;
    assign phase_end = (cnt == CNT_LAST);
    assign in_phase  = (state == LO) || (state == HI);
    assign wr_phase  = in_phase && !rd_p0;
    assign rd_phase  = in_phase && rd_p0;

`ifdef SRAM_RANGE_CHECK_EN
    // Below the base, or past the last word the half-word address bus can reach.
    assign range_bad = (addr < BASE_ADDR) ||
                       ((addr - BASE_ADDR) >= (32'd1 << (ADDR_W + 1)));
`else
    assign range_bad = 1'b0;
`endif

    // Next-state and phase counter
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = range_bad ? DONE : LO;
                end
            end
            LO: begin
                if (phase_end) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = HI;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            HI: begin
                if (phase_end) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control registers and load data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            rd_p0 <= 1'b0;
            rdata <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (start)
                rd_p0 <= mem_read;
            if (rd_phase && phase_end) begin
                if (state == LO)
                    rdata[15:0] <= sram_dq_in;
                else
                    rdata[31:16] <= sram_dq_in;
            end
        end
    end

    // Latched request payload
    always_ff @(posedge clk) begin
        if (start) begin
            widx_p0  <= (ADDR_W-1)'((addr - BASE_ADDR) >> 2);
            wdata_p0 <= wdata;
        end
    end

`ifdef SRAM_RANGE_CHECK_EN
    logic err_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_p0 <= 1'b0;
        else if (start)
            err_p0 <= range_bad;
    end

    assign err = err_p0 && (state == DONE);
`endif

    assign ready  = (state == DONE);
    assign freeze = req & ~ready;

    // we_n rises in the last cycle of each write phase so the address moves only while it is high.
    assign sram_addr   = in_phase ? {widx_p0, (state == HI)} : '0;
    assign sram_dq_out = wr_phase ? ((state == HI) ? wdata_p0[31:16] : wdata_p0[15:0]) : 16'd0;
    assign sram_dq_oe  = wr_phase;
    assign sram_we_n   = !(wr_phase && !phase_end);
    assign sram_oe_n   = !rd_phase;

endmodule
